// File: rtl/control_pkg.sv
// Control encodings for the load/store unit: access size and LSU FSM state.
package control_pkg;
  typedef enum logic [1:0] {
    DMEM_BYTE = 2'b00,
    DMEM_HALF = 2'b01,
    DMEM_WORD = 2'b10
  } dmem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } ls_state_e;

  // Encoding 11 is not a legal size; it behaves as a word access.
  function automatic dmem_size_e decode_size(input logic [1:0] n_bytes);
    case (n_bytes)
      2'b00:   decode_size = DMEM_BYTE;
      2'b01:   decode_size = DMEM_HALF;
      default: decode_size = DMEM_WORD;
    endcase
  endfunction
endpackage

// File: rtl/instructions_pkg.sv
// Core-wide instruction-level constants shared by the datapath blocks.
package instructions_pkg;
  localparam int XLEN = 32;
endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte-enables/data replication and load extract/extend.
module lsu_align
  import instructions_pkg::*;
  import control_pkg::*;
(
  input  dmem_size_e        st_size,
  input  logic [1:0]        st_off,
  input  logic [XLEN-1:0]   st_data,
  output logic [3:0]        be,
  output logic [XLEN-1:0]   wdata,
  input  dmem_size_e        ld_size,
  input  logic [1:0]        ld_off,
  input  logic              ld_unsigned,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   ld_data
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be    = 4'b0000;
    wdata = st_data;
    case (st_size)
      DMEM_BYTE: begin
        be    = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      DMEM_HALF: begin
        be    = st_off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = st_data;
      end
    endcase
  end

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_size)
      DMEM_BYTE: ld_data = ld_unsigned ? {{(XLEN-8){1'b0}}, ld_byte}
                                       : {{(XLEN-8){ld_byte[7]}}, ld_byte};
      DMEM_HALF: ld_data = ld_unsigned ? {{(XLEN-16){1'b0}}, ld_half}
                                       : {{(XLEN-16){ld_half[15]}}, ld_half};
      default:   ld_data = rdata;
    endcase
  end
endmodule

// File: rtl/load_store.sv
// Load/store unit: single outstanding data-memory access with response timeout.
// Build option MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them down.
module load_store
  import instructions_pkg::*;
  import control_pkg::*;
#(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ctrl_dmem_req,
  input  logic              ctrl_dmem_write,
  input  logic              ctrl_dmem_l_unsigned,
  input  logic [1:0]        ctrl_dmem_n_bytes,
  input  logic [XLEN-1:0]   alu_out,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              stall,
  output logic              load_valid,
  output logic [XLEN-1:0]   load_data,
  output logic              store_done,
  output logic              bus_err,
  output logic              misaligned
);
  ls_state_e       state, state_nxt;
  logic [9:0]      cnt;
  logic            timeout;
  logic            capture;

  dmem_size_e      size_in;
  logic [1:0]      off_in;
  logic            misal_in;
  logic [3:0]      be_in;
  logic [XLEN-1:0] wdata_in;
  logic [XLEN-1:0] ld_ext;

  logic [XLEN-1:0] addr_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] wdata_q;
  logic            we_q;
  logic            uns_q;
  dmem_size_e      size_q;
  logic [1:0]      off_q;

  assign size_in = decode_size(ctrl_dmem_n_bytes);

`ifdef MISALIGN_TRAP_EN
  assign misal_in = ((size_in == DMEM_HALF) && alu_out[0]) ||
                    ((size_in == DMEM_WORD) && (alu_out[1:0] != 2'b00));
  assign off_in   = alu_out[1:0];
`else
  assign misal_in = 1'b0;
  always_comb begin
    case (size_in)
      DMEM_BYTE: off_in = alu_out[1:0];
      DMEM_HALF: off_in = {alu_out[1], 1'b0};
      default:   off_in = 2'b00;
    endcase
  end
`endif

  lsu_align u_align (
    .st_size     (size_in),
    .st_off      (off_in),
    .st_data     (rs2_data),
    .be          (be_in),
    .wdata       (wdata_in),
    .ld_size     (size_q),
    .ld_off      (off_q),
    .ld_unsigned (uns_q),
    .rdata       (dmem_rdata),
    .ld_data     (ld_ext)
  );

  // Counter value k means this is the (k+1)-th cycle spent in REQ/RESP.
  assign timeout = (cnt == 10'(RESP_TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    dmem_req   = 1'b0;
    stall      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    store_done = 1'b0;
    bus_err    = 1'b0;
    misaligned = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_dmem_req) begin
          if (misal_in) begin
            misaligned = 1'b1;
          end else begin
            capture   = 1'b1;
            stall     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_gnt && we_q) begin
          dmem_req   = 1'b1;
          store_done = 1'b1;
          state_nxt  = IDLE;
        end else if (timeout) begin
          bus_err    = 1'b1;
          load_valid = !we_q;
          state_nxt  = IDLE;
        end else begin
          dmem_req = 1'b1;
          stall    = 1'b1;
          if (dmem_gnt) state_nxt = RESP;
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          load_valid = 1'b1;
          load_data  = ld_ext;
          state_nxt  = IDLE;
        end else if (timeout) begin
          bus_err    = 1'b1;
          load_valid = 1'b1;
          state_nxt  = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Keep the request-driven IDLE outputs quiet while reset is held.
    if (!rstn) begin
      stall      = 1'b0;
      misaligned = 1'b0;
    end
  end

  assign dmem_we    = dmem_req && we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) cnt <= '0;
      else               cnt <= cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= DMEM_BYTE;
      off_q   <= 2'b00;
    end else if (capture) begin
      addr_q  <= {alu_out[XLEN-1:2], 2'b00};
      be_q    <= be_in;
      wdata_q <= wdata_in;
      we_q    <= ctrl_dmem_write;
      uns_q   <= ctrl_dmem_l_unsigned;
      size_q  <= size_in;
      off_q   <= off_in;
    end
  end
endmodule

// File: tb/tb_load_store.sv
// Directed self-checking bench for load_store; a second instance with RESP_TIMEOUT=4 covers timeout.
module tb_load_store;
  logic        clk;
  logic        rstn;
  logic        ctrl_dmem_req, ctrl_dmem_write, ctrl_dmem_l_unsigned;
  logic [1:0]  ctrl_dmem_n_bytes;
  logic [31:0] alu_out, rs2_data;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  logic        dmem_req, dmem_we, stall, load_valid, store_done, bus_err, misaligned;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic [3:0]  dmem_be;

  logic        to_dmem_req, to_dmem_we, to_stall, to_load_valid, to_store_done, to_bus_err, to_misaligned;
  logic [31:0] to_dmem_addr, to_dmem_wdata, to_load_data;
  logic [3:0]  to_dmem_be;

  int checks = 0;
  int errors = 0;

  load_store u_dut (
    .clk(clk), .rstn(rstn),
    .ctrl_dmem_req(ctrl_dmem_req), .ctrl_dmem_write(ctrl_dmem_write),
    .ctrl_dmem_l_unsigned(ctrl_dmem_l_unsigned), .ctrl_dmem_n_bytes(ctrl_dmem_n_bytes),
    .alu_out(alu_out), .rs2_data(rs2_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .stall(stall), .load_valid(load_valid), .load_data(load_data),
    .store_done(store_done), .bus_err(bus_err), .misaligned(misaligned)
  );

  load_store #(.RESP_TIMEOUT(4)) u_dut_to (
    .clk(clk), .rstn(rstn),
    .ctrl_dmem_req(ctrl_dmem_req), .ctrl_dmem_write(ctrl_dmem_write),
    .ctrl_dmem_l_unsigned(ctrl_dmem_l_unsigned), .ctrl_dmem_n_bytes(ctrl_dmem_n_bytes),
    .alu_out(alu_out), .rs2_data(rs2_data),
    .dmem_req(to_dmem_req), .dmem_we(to_dmem_we), .dmem_addr(to_dmem_addr), .dmem_be(to_dmem_be),
    .dmem_wdata(to_dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .stall(to_stall), .load_valid(to_load_valid), .load_data(to_load_data),
    .store_done(to_store_done), .bus_err(to_bus_err), .misaligned(to_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; ctrl_dmem_req = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic issue(input logic we, input logic [1:0] nb, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ctrl_dmem_req = 1'b1; ctrl_dmem_write = we; ctrl_dmem_n_bytes = nb;
    ctrl_dmem_l_unsigned = uns; alu_out = a; rs2_data = d;
    #1;
    chk("issue_stall", stall, 1);
    chk("issue_no_req", dmem_req, 0);
  endtask

  task automatic do_store(input string tag, input logic [1:0] nb, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    issue(1'b1, nb, 1'b0, a, d);
    @(negedge clk); ctrl_dmem_req = 1'b0; #1;
    chk({tag, "_req"}, dmem_req, 1);
    chk({tag, "_we"}, dmem_we, 1);
    chk({tag, "_addr"}, dmem_addr, exp_addr);
    chk({tag, "_be"}, dmem_be, exp_be);
    chk({tag, "_wdata"}, dmem_wdata, exp_wd);
    chk({tag, "_stall_wait"}, stall, 1);
    chk({tag, "_sd_early"}, store_done, 0);
    @(negedge clk); dmem_gnt = 1'b1; #1;
    chk({tag, "_done"}, store_done, 1);
    chk({tag, "_stall_done"}, stall, 0);
    @(negedge clk); dmem_gnt = 1'b0; #1;
    chk({tag, "_done_pulse"}, store_done, 0);
    chk({tag, "_req_off"}, dmem_req, 0);
  endtask

  task automatic do_load(input string tag, input logic [1:0] nb, input logic uns,
                         input logic [31:0] a, input logic [31:0] rd,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_ld);
    issue(1'b0, nb, uns, a, 32'h0);
    // rvalid during REQ must not complete the load
    @(negedge clk); ctrl_dmem_req = 1'b0; dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = rd; #1;
    chk({tag, "_req"}, dmem_req, 1);
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_addr"}, dmem_addr, exp_addr);
    chk({tag, "_be"}, dmem_be, exp_be);
    chk({tag, "_lv_in_req"}, load_valid, 0);
    @(negedge clk); dmem_gnt = 1'b0; #1;
    chk({tag, "_lv"}, load_valid, 1);
    chk({tag, "_data"}, load_data, exp_ld);
    chk({tag, "_stall"}, stall, 0);
    @(negedge clk); dmem_rvalid = 1'b0; #1;
    chk({tag, "_lv_pulse"}, load_valid, 0);
  endtask

  initial begin
    rstn = 1'b0; ctrl_dmem_req = 1'b0; ctrl_dmem_write = 1'b0; ctrl_dmem_l_unsigned = 1'b0;
    ctrl_dmem_n_bytes = 2'b00; alu_out = '0; rs2_data = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    #3;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_ld", load_data, 0);
    chk("rst_lv", load_valid, 0);
    do_reset();

    // Stores: byte/half/word lane placement
    do_store("st_b",  2'b00, 32'h0000_0103, 32'h0000_00AB, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB);
    do_store("st_h",  2'b01, 32'h0000_0102, 32'h1234_ABCD, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD);
    do_store("st_w",  2'b10, 32'h0000_0204, 32'hCAFE_F00D, 32'h0000_0204, 4'b1111, 32'hCAFE_F00D);
    do_store("st_w3", 2'b11, 32'h0000_0208, 32'h1122_3344, 32'h0000_0208, 4'b1111, 32'h1122_3344);

    // Loads: sign/zero extension
    do_load("ld_hs", 2'b01, 1'b0, 32'h0000_0102, 32'h8001_1234, 32'h0000_0100, 4'b1100, 32'hFFFF_8001);
    do_load("ld_hu", 2'b01, 1'b1, 32'h0000_0102, 32'h8001_1234, 32'h0000_0100, 4'b1100, 32'h0000_8001);
    do_load("ld_bs", 2'b00, 1'b0, 32'h0000_0103, 32'h8001_1234, 32'h0000_0100, 4'b1000, 32'hFFFF_FF80);
    do_load("ld_bu", 2'b00, 1'b1, 32'h0000_0101, 32'h8001_1234, 32'h0000_0100, 4'b0010, 32'h0000_0012);
    do_load("ld_w",  2'b10, 1'b0, 32'h0000_0300, 32'h8001_1234, 32'h0000_0300, 4'b1111, 32'h8001_1234);

    // Word load with grant held off for five cycles
    do_reset();
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); ctrl_dmem_req = 1'b0; #1;
      chk("wait_req", dmem_req, 1);
      chk("wait_stall", stall, 1);
      chk("wait_addr", dmem_addr, 32'h0000_0200);
      chk("wait_be", dmem_be, 4'b1111);
    end
    @(negedge clk); dmem_gnt = 1'b1; #1;
    chk("wait_gnt_stall", stall, 1);
    @(negedge clk); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1;
    chk("wait_lv", load_valid, 1);
    chk("wait_data", load_data, 32'hDEAD_BEEF);
    @(negedge clk); dmem_rvalid = 1'b0;

    // Timeout in RESP on the 4th counted cycle (RESP_TIMEOUT=4 instance)
    do_reset();
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
    @(negedge clk); ctrl_dmem_req = 1'b0; dmem_gnt = 1'b1; #1;
    chk("to1_req", to_dmem_req, 1);
    @(negedge clk); dmem_gnt = 1'b0; #1;
    chk("to2_err", to_bus_err, 0);
    @(negedge clk); #1;
    chk("to3_err", to_bus_err, 0);
    chk("to3_stall", to_stall, 1);
    @(negedge clk); #1;
    chk("to4_err", to_bus_err, 1);
    chk("to4_lv", to_load_valid, 1);
    chk("to4_data", to_load_data, 0);
    chk("to4_stall", to_stall, 0);
    @(negedge clk); #1;
    chk("to5_err_pulse", to_bus_err, 0);
    chk("to5_lv_pulse", to_load_valid, 0);

    // rvalid in the timeout cycle completes normally
    do_reset();
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0402, 32'h0);
    @(negedge clk); ctrl_dmem_req = 1'b0; dmem_gnt = 1'b1; #1;
    @(negedge clk); dmem_gnt = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_1234; #1;
    chk("tor_err", to_bus_err, 0);
    chk("tor_lv", to_load_valid, 1);
    chk("tor_data", to_load_data, 32'hFFFF_8001);
    @(negedge clk); dmem_rvalid = 1'b0;

    // Timeout in REQ for a store without grant: bus_err only, request dropped
    do_reset();
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0500, 32'h5555_AAAA);
    @(negedge clk); ctrl_dmem_req = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("tos3_req", to_dmem_req, 1);
    @(negedge clk); #1;
    chk("tos4_err", to_bus_err, 1);
    chk("tos4_req", to_dmem_req, 0);
    chk("tos4_lv", to_load_valid, 0);
    chk("tos4_sd", to_store_done, 0);

    // Misaligned half load
    do_reset();
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    ctrl_dmem_req = 1'b1; ctrl_dmem_write = 1'b0; ctrl_dmem_n_bytes = 2'b01; alu_out = 32'h0000_0101; #1;
    chk("mis_flag", misaligned, 1);
    chk("mis_stall", stall, 0);
    @(negedge clk); ctrl_dmem_req = 1'b0; #1;
    chk("mis_no_req", dmem_req, 0);
    chk("mis_pulse", misaligned, 0);
`else
    chk("mis_tied", misaligned, 0);
    do_load("mis_al", 2'b01, 1'b0, 32'h0000_0101, 32'h8001_1234, 32'h0000_0100, 4'b0011, 32'h0000_1234);
`endif

    // Reset while in RESP aborts and later rvalid is ignored
    do_reset();
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0);
    @(negedge clk); ctrl_dmem_req = 1'b0; dmem_gnt = 1'b1; #1;
    @(negedge clk); dmem_gnt = 1'b0; #1;
    chk("rr_stall_pre", stall, 1);
    @(negedge clk); rstn = 1'b0; #1;
    chk("rr_stall", stall, 0);
    chk("rr_be", dmem_be, 0);
    chk("rr_addr", dmem_addr, 0);
    chk("rr_lv", load_valid, 0);
    chk("rr_ld", load_data, 0);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678; #1;
    chk("rr_late_lv", load_valid, 0);
    chk("rr_late_ld", load_data, 0);
    chk("rr_late_stall", stall, 0);
    @(negedge clk); dmem_rvalid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
